rf_wb_ctrl: RTL
===============

Name: rf_wb_ctrl

Overview:
- Write-back controller: the initiator side of the register-file write port.
- Merges single-cycle ALU results with long-latency memory/MDU results into the one regfile write port (WE/A3/WD3 on the regfile).
- Buffers memory results in a small FIFO and arbitrates with an anti-starvation rule.
- Provides bypass data for results that are accepted but not yet committed, so the two read ports see them.

Parameters:
- DEPTH, 4, memory-result FIFO entries (power of two, ≥2).
- STARVE_MAX, 3, consecutive cycles a FIFO head may be denied before it forces the write port.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  memory/MDU result present.
- mem_ready  out  1  FIFO can accept a result.
- mem_rd  in  5  memory destination register.
- mem_data  in  32  memory result.
- rf_we  out  1  to regfile WE.
- rf_waddr  out  5  to regfile A3.
- rf_wdata  out  32  to regfile WD3.
- rs1, rs2  in  5 each  decode-stage read addresses (same as regfile A1/A2).
- byp1_hit, byp2_hit  out  1 each  pending write matches rs1/rs2.
- byp1_data, byp2_data  out  32 each  pending value for rs1/rs2.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, pending=0, starve counter=0.
  - After release: alu_ready=1, mem_ready=1.
- Output stage: rf_we/rf_waddr/rf_wdata are registered. A result selected in cycle N appears on rf_* in cycle N+1. The regfile commits it at the end of N+1.
- mem_ready = (count < DEPTH).
  - Combinational from state only; no same-cycle pop pass-through.
  - A full FIFO deasserts ready even if it pops that cycle.
- Memory push: on mem_valid && mem_ready.
  - Entry {mem_rd, mem_data} is written at the tail.
  - If mem_rd == 0, the handshake completes but nothing is enqueued.
  - Memory results always pass through the FIFO. Minimum latency from accept to rf_we=1 is 2 cycles.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- force = (starve counter == STARVE_MAX) && FIFO non-empty.
- alu_ready = !force.
- Selection each cycle, in priority order:
  1. force: pop the FIFO head into the output stage. The ALU is stalled.
  2. Else if alu_valid and alu_rd != 0: load the ALU result.
  3. Else if the FIFO is non-empty: pop the head.
  4. Else: rf_we <= 0.
- ALU result with alu_rd == 0: accepted (alu_ready=1), discarded, does not block a FIFO pop that cycle.
- Simultaneous push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Bypass, per port (rs1/rs2 independently):
  - rs == 0: hit=0, data=0.
  - Otherwise hit if the output stage (rf_we=1, rf_waddr==rs) or any valid FIFO entry matches.
  - Priority: FIFO youngest to oldest, then the output stage (youngest data wins).
  - Combinational; data=0 when no hit.
  - The newly selected ALU result is not bypassed here; the pipeline's own ALU forwarding covers it.
- Ordering contract: upstream guarantees at most one in-flight write per rd across ALU and memory. The block does not reorder-protect WAW. The bench asserts this contract.
- Reset mid-operation: the FIFO contents and the output stage are discarded immediately, and rf_we drops asynchronously. Results accepted before reset are lost by design.

Decomposition:
- Shared package (rf_pkg): XLEN=32, REG_AW=5, REG_ZERO=5'd0, struct/typedef wb_entry_t {rd, data}.
- One sub-module: rf_wb_fifo.
  - Parameterised DEPTH, synchronous FIFO with async active-low reset.
  - Exports entry array plus valid bits for the bypass search.
- Arbitration, starve counter and bypass stay in rf_wb_ctrl.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234 in cycle 1 → cycle 2 rf_we=1, rf_waddr=5, rf_wdata=0x1234; regfile x5=0x1234 in cycle 3; byp1_hit=1 for rs1=5 in cycle 2.
- Memory only: push rd=7, data=0xDEAD with ALU idle → rf_we=1, waddr=7 exactly 2 cycles later. Also push rd=0 → no write, pending stays 0.
- Full and backpressure: hold alu_valid (rd≠0) and push 4 memory results → mem_ready=0 at pending=4.
  - The starve limit forces one pop after STARVE_MAX cycles, with alu_ready=0 for that cycle; mem_ready recovers next cycle.
  - All 4 memory results are committed in FIFO order.
- Starvation: continuous ALU traffic plus 1 FIFO entry → the FIFO entry reaches rf_we within STARVE_MAX+2 cycles; alu_ready low for exactly 1 cycle.
- Bypass priority: FIFO holds rd=9 (0xA) and the output stage holds rd=3 (0xB); rs1=9, rs2=3 → byp1_data=0xA, byp2_data=0xB. With rs1=0, hit=0 and data=0.
- Async reset with 3 entries pending and rf_we=1 → outputs go to 0 before the next edge, pending=0, and no further writes after reset release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Result of a bypass lookup for one read port.
  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } byp_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of pending memory/MDU write-backs. The whole entry array,
// per-slot valid bits and the read pointer are exported so the controller can
// search pending writes oldest-to-youngest for bypassing.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  wb_entry_t                    din,
  output wb_entry_t                    head,
  output wb_entry_t [DEPTH-1:0]        entries,
  output logic [DEPTH-1:0]             valid,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  wb_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0]         wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);

  // Entry storage: written at the tail on every accepted push.
  // NOTE: storage has no reset; the valid bits alone decide what is live, and
  // leaving the array reset-free lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and per-slot valid bits; pointers wrap modulo DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: merges single-cycle ALU results and FIFO-buffered
// memory/MDU results onto the single register-file write port, with an
// anti-starvation rule for the FIFO head and bypass of not-yet-committed data.
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic [XLEN-1:0]        mem_data,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  input  logic [REG_AW-1:0]      rs1,
  input  logic [REG_AW-1:0]      rs2,
  output logic                   byp1_hit,
  output logic                   byp2_hit,
  output logic [XLEN-1:0]        byp1_data,
  output logic [XLEN-1:0]        byp2_data,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]     FULL       = (AW+1)'(DEPTH);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  wb_entry_t             fifo_din;
  wb_entry_t             fifo_head;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;
  logic [AW-1:0]         fifo_rd_ptr;
  logic [AW:0]           fifo_count;

  logic [SW-1:0] starve;
  logic          non_empty;
  logic          force_pop;
  logic          alu_take;
  logic          push;
  logic          pop;
  byp_t          byp1;
  byp_t          byp2;

  // Handshake and arbitration decisions; all derive from registered state plus
  // this cycle's inputs.
  assign non_empty = (fifo_count != '0);
  assign force_pop = (starve == STARVE_LIM) && non_empty;
  assign alu_ready = !force_pop;
  assign mem_ready = (fifo_count != FULL);
  assign alu_take  = !force_pop && alu_valid && (alu_rd != REG_ZERO);
  assign pop       = non_empty && (force_pop || !alu_take);
  assign push      = mem_valid && mem_ready && (mem_rd != REG_ZERO);
  assign fifo_din  = '{rd: mem_rd, data: mem_data};
  assign pending   = fifo_count;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (fifo_din),
    .head    (fifo_head),
    .entries (fifo_entries),
    .valid   (fifo_valid),
    .rd_ptr  (fifo_rd_ptr),
    .count   (fifo_count)
  );

  // Count cycles the FIFO head waits; saturates so force stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (!non_empty || pop) begin
      starve <= '0;
    end else if (starve != STARVE_LIM) begin
      starve <= starve + 1'b1;
    end
  end

  // Registered write port: the winner of this cycle's arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= fifo_head.rd;
      rf_wdata <= fifo_head.data;
    end else if (alu_take) begin
      rf_we    <= 1'b1;
      rf_waddr <= alu_rd;
      rf_wdata <= alu_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Search pending writes for rs: output stage first, then FIFO oldest to
  // youngest so the youngest match overrides.
  function automatic byp_t lookup(
    input logic [REG_AW-1:0]   rs,
    input logic                we,
    input logic [REG_AW-1:0]   waddr,
    input logic [XLEN-1:0]     wdata,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [DEPTH-1:0]    vld,
    input logic [AW-1:0]       head_ptr
  );
    byp_t          r;
    logic [AW-1:0] idx;
    // NOTE: r is defaulted before any branch so every path assigns it; an
    // unassigned path would make the calling always_comb infer a latch.
    r   = '0;
    idx = '0;
    if (rs != REG_ZERO) begin
      if (we && (waddr == rs)) r = '{hit: 1'b1, data: wdata};
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + AW'(k);
        if (vld[idx] && (ents[idx].rd == rs)) r = '{hit: 1'b1, data: ents[idx].data};
      end
    end
    return r;
  endfunction

  // Bypass lookups for both decode read ports.
  always_comb begin
    byp1 = lookup(rs1, rf_we, rf_waddr, rf_wdata, fifo_entries, fifo_valid, fifo_rd_ptr);
    byp2 = lookup(rs2, rf_we, rf_waddr, rf_wdata, fifo_entries, fifo_valid, fifo_rd_ptr);
  end

  assign byp1_hit  = byp1.hit;
  assign byp1_data = byp1.data;
  assign byp2_hit  = byp2.hit;
  assign byp2_data = byp2.data;

endmodule
